piezo_tone_decoder: RTL

//  Listens to the differential piezo pair and decodes it back into notes: measures the period of each tone,

---
 rtl/piezo_tone_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/piezo_tone_decoder.sv
// piezo_tone_decoder
//   Monitors the differential piezo drive and decodes it back into notes.
//   The period of each tone is measured between rising edges of the positive
//   leg and classified as G6/C7/E7/G7 (or NONE). Contiguous periods of the
//   same class are merged into one note, which is reported with its length
//   in clk cycles. Optional melody recognition is compiled in when the macro
//   PIEZO_DEC_MELODY_EN is defined; otherwise melody_vld/melody_id are tied 0.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   piezo, piezo_n  piezo drive legs (monitored)
//   note_vld        1-cycle pulse when a note ends
//   note_id         0=NONE 1=G6 2=C7 3=E7 4=G7, held until next note_vld
//   note_len        note length (sum of its periods), held as note_id
//   diff_err        legs equal for >=2 consecutive samples
//   melody_vld      1-cycle pulse on melody decision (macro build only)
//   melody_id       0=UNKNOWN 1=STEER 2=BATT 3=FAST, held until next pulse
module piezo_tone_decoder #(
  parameter bit FAST_SIM = 1'b1,
  parameter int CNT_W    = 16,
  parameter int LEN_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             piezo,
  input  logic             piezo_n,
  output logic             note_vld,
  output logic [2:0]       note_id,
  output logic [LEN_W-1:0] note_len,
  output logic             diff_err,
  output logic             melody_vld,
  output logic [1:0]       melody_id
);

  localparam int unsigned TOL  = FAST_SIM ? 2     : 64;
  localparam int unsigned SIL  = FAST_SIM ? 128   : 65535;
  localparam int unsigned P_G6 = FAST_SIM ? 63    : 31889;
  localparam int unsigned P_C7 = FAST_SIM ? 47    : 23891;
  localparam int unsigned P_E7 = FAST_SIM ? 38    : 18962;
  localparam int unsigned P_G7 = FAST_SIM ? 32    : 15945;
  localparam int          SW   = LEN_W + 1;
  localparam logic [CNT_W-1:0] SIL_C   = CNT_W'(SIL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, TONE} state_t;

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    int unsigned v;
    v = 32'(p);
    classify = 3'd0;
    if (v + TOL >= P_G6 && v <= P_G6 + TOL) classify = 3'd1;
    if (v + TOL >= P_C7 && v <= P_C7 + TOL) classify = 3'd2;
    if (v + TOL >= P_E7 && v <= P_E7 + TOL) classify = 3'd3;
    if (v + TOL >= P_G7 && v <= P_G7 + TOL) classify = 3'd4;
  endfunction

  state_t           state;
  logic             piezo_s, piezo_n_s, piezo_q, eq_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur_id;
  logic [LEN_W-1:0] len;

  logic             rise, eq, silent, emit_chg, emit_sil;
  logic [2:0]       cls;
  logic [SW-1:0]    sum;
  logic [LEN_W-1:0] len_sat;

  always_comb begin
    rise     = piezo_s & ~piezo_q;
    eq       = (piezo_s == piezo_n_s);
    cls      = classify(cnt);
    silent   = (cnt == SIL_C);
    // an edge in the same cycle as the silence threshold takes priority
    emit_chg = (state == TONE) && rise && (cls != cur_id);
    emit_sil = (state == TONE) && !rise && silent;
    sum      = {1'b0, len} + SW'(cnt);
    len_sat  = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      piezo_s   <= 1'b0;
      piezo_n_s <= 1'b0;
      piezo_q   <= 1'b0;
      eq_q      <= 1'b0;
      diff_err  <= 1'b0;
      cnt       <= '0;
      cur_id    <= 3'd0;
      len       <= '0;
      note_vld  <= 1'b0;
      note_id   <= 3'd0;
      note_len  <= '0;
    end else begin
      piezo_s   <= piezo;
      piezo_n_s <= piezo_n;
      piezo_q   <= piezo_s;
      eq_q      <= eq;
      diff_err  <= eq & eq_q;
      if (rise)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      note_vld <= 1'b0;
      if (emit_chg || emit_sil) begin
        note_vld <= 1'b1;
        note_id  <= cur_id;
        note_len <= len;
      end
      case (state)
        IDLE: if (rise) state <= ACQ;
        ACQ: begin
          if (rise) begin
            state  <= TONE;
            cur_id <= cls;
            len    <= LEN_W'(cnt);
          end else if (silent) begin
            state <= IDLE;
          end
        end
        TONE: begin
          if (rise) begin
            if (cls == cur_id) begin
              len <= len_sat;
            end else begin
              cur_id <= cls;
              len    <= LEN_W'(cnt);
            end
          end else if (silent) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIEZO_DEC_MELODY_EN
  // hist[0] is the most recently emitted note
  localparam logic [5:0][2:0] STEER = {3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
  localparam logic [5:0][2:0] BATT  = {3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};

  logic [5:0][2:0] hist, hist_next;
  logic            fast_hit;

  always_comb begin
    hist_next = {hist[4:0], cur_id};
    // E7 ending on a G6 edge right after G6,C7
    fast_hit  = emit_chg && (cur_id == 3'd3) && (cls == 3'd1) &&
                (hist[0] == 3'd2) && (hist[1] == 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist       <= '0;
      melody_vld <= 1'b0;
      melody_id  <= 2'd0;
    end else begin
      melody_vld <= 1'b0;
      if (emit_sil) begin
        melody_vld <= 1'b1;
        hist       <= '0;
        if (hist_next == STEER)     melody_id <= 2'd1;
        else if (hist_next == BATT) melody_id <= 2'd2;
        else                        melody_id <= 2'd0;
      end else if (emit_chg) begin
        if (fast_hit) begin
          melody_vld <= 1'b1;
          melody_id  <= 2'd3;
          hist       <= '0;
        end else begin
          hist <= hist_next;
        end
      end
    end
  end
`else
  assign melody_vld = 1'b0;
  assign melody_id  = 2'd0;
`endif

endmodule
